// File: rtl/seqdiv_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and counter sizing.
// Latency: none; this file holds only types and constant functions.
// Backpressure: not applicable.
package seqdiv_pkg;

  // IDLE waits for start, CALC runs one restoring step per clock, FIX applies signs.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // The iteration counter must be able to hold the value WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seqdiv_nbitsub.sv
// N-bit subtractor with borrow out, used as the divider's per-cycle trial subtract.
// Latency: combinational.
// Backpressure: none.
module seqdiv_nbitsub #(
  parameter int N = 7
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_o
);

  // Borrow is the extra top bit of a zero-extended subtraction; set when b_i > a_i.
  assign {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};

endmodule

// File: rtl/seqdiv.sv
// Restoring shift-subtract divider, signed or unsigned, with a start/busy/done handshake.
// Latency: done WIDTH+1 cycles after the accepting edge; 1 cycle on divide-by-zero.
// Backpressure: start is ignored while busy; no pipelining, one division in flight.
module seqdiv
  import seqdiv_pkg::*;
#(
  parameter int WIDTH  = 6,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             err
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  // dvd_q starts as the dividend magnitude and is progressively replaced by quotient bits.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sdvd_q, sdvd_d;
  logic             sdsr_q, sdsr_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   trial_a;
  logic [WIDTH:0]   trial_diff;
  logic             trial_borrow;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;

  // Partial remainder shifted left with the next dividend MSB brought in.
  assign trial_a = (rem_q << 1) | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};

  seqdiv_nbitsub #(.N(WIDTH + 1)) u_trial (
    .a_i      (trial_a),
    .b_i      ({1'b0, dsr_q}),
    .diff_o   (trial_diff),
    .borrow_o (trial_borrow)
  );

  // On divide-by-zero CALC is skipped, so dvd_q still holds the dividend magnitude and
  // re-applying the dividend sign in FIX reproduces the original dividend exactly.
  assign q_mag = dz_q ? '0 : dvd_q;
  assign r_mag = dz_q ? dvd_q : rem_q[WIDTH-1:0];

  // Next-state and datapath: accept in IDLE, iterate in CALC, sign-correct in FIX.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    sdvd_d  = sdvd_q;
    sdsr_d  = sdsr_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sdvd_d  = SIGNED & dividend[WIDTH-1];
          sdsr_d  = SIGNED & divisor[WIDTH-1];
          dvd_d   = (SIGNED & dividend[WIDTH-1]) ? -dividend : dividend;
          dsr_d   = (SIGNED & divisor[WIDTH-1]) ? -divisor : divisor;
          rem_d   = '0;
          cnt_d   = '0;
          dz_d    = (divisor == '0);
          ovf_d   = SIGNED && (dividend == MOST_NEG) && (divisor == '1);
          state_d = (divisor == '0) ? ST_FIX : ST_CALC;
        end
      end
      ST_CALC: begin
        rem_d = trial_borrow ? trial_a : trial_diff;
        dvd_d = {dvd_q[WIDTH-2:0], ~trial_borrow};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        quo_d   = (sdvd_q ^ sdsr_q) ? -q_mag : q_mag;
        rmd_d   = sdvd_q ? -r_mag : r_mag;
        err_d   = dz_q | ovf_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation and clears all results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      sdvd_q  <= 1'b0;
      sdsr_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      sdvd_q  <= sdvd_d;
      sdsr_q  <= sdsr_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seqdiv.sv
// Bench for seqdiv: a 6-bit signed and an 8-bit unsigned instance against an arithmetic model.
// Latency: checks done timing (WIDTH+1 cycles, 1 on divide-by-zero) and busy span.
// Backpressure: checks that start is ignored while busy and accepted in the done cycle.
module tb_seqdiv;

  logic       clk;
  logic       rst_n;
  logic       start6, start8;
  logic [5:0] dvd6, dsr6, q6, r6;
  logic [7:0] dvd8, dsr8, q8, r8;
  logic       busy6, done6, e6, busy8, done8, e8;

  int checks = 0;
  int errors = 0;

  seqdiv #(.WIDTH(6), .SIGNED(1'b1)) u_d6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .dividend(dvd6), .divisor(dsr6),
    .busy(busy6), .done(done6), .quotient(q6), .remainder(r6), .err(e6)
  );

  seqdiv #(.WIDTH(8), .SIGNED(1'b0)) u_d8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .dividend(dvd8), .divisor(dsr8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .err(e8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // Reference: plain integer division truncating toward zero, remainder takes dividend sign.
  function automatic void model(input bit wide, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r, output logic e);
    int w, lim, sa, sb;
    bit sgn;
    w   = wide ? 8 : 6;
    sgn = !wide;
    lim = 1 << w;
    sa  = (sgn && a[w-1]) ? int'(a) - lim : int'(a);
    sb  = (sgn && b[w-1]) ? int'(b) - lim : int'(b);
    if (sb == 0) begin
      q = 8'h00; r = a; e = 1'b1;
    end else if (sgn && sa == -(lim / 2) && sb == -1) begin
      q = a; r = 8'h00; e = 1'b1;
    end else begin
      q = 8'((sa / sb) & (lim - 1));
      r = 8'((sa % sb) & (lim - 1));
      e = 1'b0;
    end
  endfunction

  // Issue one start (caller is #1 after a rising edge with the DUT idle) and wait for done.
  // lat = edges from the accepting edge to done; bcnt = sampled cycles with busy high.
  task automatic do_op(input bit wide, input logic [7:0] a, input logic [7:0] b,
                       output int lat, output int bcnt);
    if (wide) begin start8 = 1'b1; dvd8 = a; dsr8 = b; end
    else begin start6 = 1'b1; dvd6 = a[5:0]; dsr6 = b[5:0]; end
    @(posedge clk); #1;
    start6 = 1'b0; start8 = 1'b0;
    lat = 0; bcnt = 0;
    while (lat < 50) begin
      if (wide ? done8 : done6) break;
      if (wide ? busy8 : busy6) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    logic [5:0] o6 [5];
    logic [7:0] o8 [5];
    rst_n = 1'b0;
    start6 = 1'b0; start8 = 1'b0; dvd6 = '0; dsr6 = '0; dvd8 = '0; dsr8 = '0;
    #12;
    o6 = '{6'(busy6), 6'(done6), q6, r6, 6'(e6)};
    o8 = '{8'(busy8), 8'(done8), q8, r8, 8'(e8)};
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (o6[i] !== 6'h00) begin errors++; $display("FAIL reset6[%0d] got %h want 00", i, o6[i]); end
      checks++;
      if (o8[i] !== 8'h00) begin errors++; $display("FAIL reset8[%0d] got %h want 00", i, o8[i]); end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_signed;
    logic [7:0] ta [3] = '{8'h0D, 8'h33, 8'h0D};
    logic [7:0] tb [3] = '{8'h03, 8'h03, 8'h3D};
    logic [5:0] eq [3] = '{6'h04, 6'h3C, 6'h3C};
    logic [5:0] er [3] = '{6'h01, 6'h3F, 6'h01};
    int lat, bcnt;
    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, ta[i], tb[i], lat, bcnt);
      checks++; if (lat !== 7) begin errors++; $display("FAIL signed_lat[%0d] got %0d want 7", i, lat); end
      checks++; if (bcnt !== 7) begin errors++; $display("FAIL signed_busy[%0d] got %0d want 7", i, bcnt); end
      checks++; if (busy6 !== 1'b0) begin errors++; $display("FAIL signed_busy_done[%0d] got %b want 0", i, busy6); end
      checks++; if (q6 !== eq[i]) begin errors++; $display("FAIL signed_q[%0d] got %h want %h", i, q6, eq[i]); end
      checks++; if (r6 !== er[i]) begin errors++; $display("FAIL signed_r[%0d] got %h want %h", i, r6, er[i]); end
      checks++; if (e6 !== 1'b0) begin errors++; $display("FAIL signed_err[%0d] got %b want 0", i, e6); end
    end
  endtask

  task automatic test_zero_overflow;
    int lat, bcnt;
    do_op(1'b0, 8'h0D, 8'h00, lat, bcnt);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dz_lat got %0d want 1", lat); end
    checks++; if (e6 !== 1'b1) begin errors++; $display("FAIL dz_err got %b want 1", e6); end
    checks++; if (q6 !== 6'h00) begin errors++; $display("FAIL dz_q got %h want 00", q6); end
    checks++; if (r6 !== 6'h0D) begin errors++; $display("FAIL dz_r got %h want 0d", r6); end
    do_op(1'b0, 8'h20, 8'h3F, lat, bcnt);
    checks++; if (lat !== 7) begin errors++; $display("FAIL ovf_lat got %0d want 7", lat); end
    checks++; if (e6 !== 1'b1) begin errors++; $display("FAIL ovf_err got %b want 1", e6); end
    checks++; if (q6 !== 6'h20) begin errors++; $display("FAIL ovf_q got %h want 20", q6); end
    checks++; if (r6 !== 6'h00) begin errors++; $display("FAIL ovf_r got %h want 00", r6); end
  endtask

  task automatic test_ignored_start;
    int lat;
    logic [5:0] q_prev;
    q_prev = q6;
    start6 = 1'b1; dvd6 = 6'd13; dsr6 = 6'd3;
    @(posedge clk); #1;
    start6 = 1'b0;
    lat = 0;
    while (!done6 && lat < 50) begin
      start6 = (lat == 2);
      if (lat == 2) begin dvd6 = 6'd20; dsr6 = 6'd6; end
      if (lat == 4) begin
        checks++;
        if (q6 !== q_prev) begin errors++; $display("FAIL ign_hold_q got %h want %h", q6, q_prev); end
      end
      @(posedge clk); #1;
      lat++;
    end
    start6 = 1'b0;
    checks++; if (lat !== 7) begin errors++; $display("FAIL ign_lat got %0d want 7", lat); end
    checks++; if (q6 !== 6'd4) begin errors++; $display("FAIL ign_q got %0d want 4", q6); end
    checks++; if (r6 !== 6'd1) begin errors++; $display("FAIL ign_r got %0d want 1", r6); end
    @(posedge clk); #1;
    checks++; if (busy6 !== 1'b0) begin errors++; $display("FAIL ign_no_restart got %b want 0", busy6); end
  endtask

  task automatic test_back_to_back;
    int lat, bcnt;
    do_op(1'b0, 8'd13, 8'd3, lat, bcnt);
    // Still in the done cycle: issue the next start immediately.
    do_op(1'b0, 8'd20, 8'd6, lat, bcnt);
    checks++; if (lat !== 7) begin errors++; $display("FAIL b2b_lat got %0d want 7", lat); end
    checks++; if (bcnt !== 7) begin errors++; $display("FAIL b2b_busy got %0d want 7", bcnt); end
    checks++; if (q6 !== 6'd3) begin errors++; $display("FAIL b2b_q got %0d want 3", q6); end
    checks++; if (r6 !== 6'd2) begin errors++; $display("FAIL b2b_r got %0d want 2", r6); end
  endtask

  task automatic test_reset_mid;
    int lat, bcnt, pulses;
    start6 = 1'b1; dvd6 = 6'd13; dsr6 = 6'd3;
    @(posedge clk); #1;
    start6 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++; if (busy6 !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy6); end
    checks++; if (q6 !== 6'h00) begin errors++; $display("FAIL rmid_q got %h want 00", q6); end
    checks++; if (r6 !== 6'h00) begin errors++; $display("FAIL rmid_r got %h want 00", r6); end
    checks++; if (e6 !== 1'b0) begin errors++; $display("FAIL rmid_err got %b want 0", e6); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done6) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rmid_done got %0d pulses want 0", pulses); end
    do_op(1'b0, 8'd20, 8'd6, lat, bcnt);
    checks++; if (q6 !== 6'd3) begin errors++; $display("FAIL rmid_after_q got %0d want 3", q6); end
    checks++; if (r6 !== 6'd2) begin errors++; $display("FAIL rmid_after_r got %0d want 2", r6); end
  endtask

  task automatic test_unsigned;
    int lat, bcnt;
    do_op(1'b1, 8'd250, 8'd7, lat, bcnt);
    checks++; if (lat !== 9) begin errors++; $display("FAIL u_lat got %0d want 9", lat); end
    checks++; if (q8 !== 8'd35) begin errors++; $display("FAIL u_q got %0d want 35", q8); end
    checks++; if (r8 !== 8'd5) begin errors++; $display("FAIL u_r got %0d want 5", r8); end
    do_op(1'b1, 8'h80, 8'hFF, lat, bcnt);
    checks++; if (q8 !== 8'h00) begin errors++; $display("FAIL u_big_q got %h want 00", q8); end
    checks++; if (r8 !== 8'h80) begin errors++; $display("FAIL u_big_r got %h want 80", r8); end
    checks++; if (e8 !== 1'b0) begin errors++; $display("FAIL u_big_err got %b want 0", e8); end
  endtask

  task automatic test_random;
    int lat, bcnt, exp_lat;
    bit wide;
    logic [7:0] a, b, eq, er, gq, gr;
    logic ee, ge;
    for (int i = 0; i < 80; i++) begin
      wide = i[0];
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if (!wide) begin a = a & 8'h3F; b = b & 8'h3F; end
      if (i % 10 == 4) begin a = 8'h20; b = 8'h3F; end
      model(wide, a, b, eq, er, ee);
      exp_lat = (b == 8'h00) ? 1 : (wide ? 9 : 7);
      do_op(wide, a, b, lat, bcnt);
      gq = wide ? q8 : {2'b00, q6};
      gr = wide ? r8 : {2'b00, r6};
      ge = wide ? e8 : e6;
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rnd_lat[%0d] %h/%h got %0d want %0d", i, a, b, lat, exp_lat); end
      checks++; if (gq !== eq) begin errors++; $display("FAIL rnd_q[%0d] %h/%h got %h want %h", i, a, b, gq, eq); end
      checks++; if (gr !== er) begin errors++; $display("FAIL rnd_r[%0d] %h/%h got %h want %h", i, a, b, gr, er); end
      checks++; if (ge !== ee) begin errors++; $display("FAIL rnd_err[%0d] %h/%h got %b want %b", i, a, b, ge, ee); end
    end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_zero_overflow();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_unsigned();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
